// File: rtl/ibis_wave_sequencer.sv
// rtl/ibis_wave_sequencer.sv - wavetable position sequencer, 32-nibble wave RAM and volume stage
// Optional auto-stop length counter: IBIS_WAVE_SEQUENCER_LENGTH_EN
module ibis_wave_sequencer (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       enable,
  input  logic       tick,
  input  logic       trigger,
  input  logic       ram_we,
  input  logic [3:0] ram_addr,
  input  logic [7:0] ram_wdata,
  input  logic [1:0] volume,
  input  logic       length_load,
  input  logic [7:0] length_in,
  output logic [3:0] sample_out,
  output logic       sample_valid,
  output logic       active,
  output logic [4:0] position_out
);

  logic [7:0] wave_ram [16];
  logic       s0_valid;
  logic [4:0] s0_pos;
  logic       s1_valid;
  logic [3:0] s1_nib;
  logic       take_trig;
  logic       take_tick;
  logic       len_expire;
  logic [7:0] rd_byte;
  logic [3:0] rd_nib;
  logic [3:0] atten;

  // Host port is independent of enable/active; nonblocking write gives read-before-write
  always_ff @(posedge aclk) begin
    if (ram_we) begin
      wave_ram[ram_addr] <= ram_wdata;
    end
  end

  assign take_trig = enable & trigger;
  assign take_tick = enable & tick & active & ~trigger;

  assign rd_byte = wave_ram[s0_pos[4:1]];
  assign rd_nib  = s0_pos[0] ? rd_byte[3:0] : rd_byte[7:4];

  always_comb begin
    atten = 4'd0;
    case (volume)
      2'd0: atten = 4'd0;
      2'd1: atten = s1_nib;
      2'd2: atten = {1'b0, s1_nib[3:1]};
      2'd3: atten = {2'b00, s1_nib[3:2]};
      default: atten = 4'd0;
    endcase
  end

`ifdef IBIS_WAVE_SEQUENCER_LENGTH_EN
  logic [7:0] len_cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      len_cnt <= 8'd0;
    end else if (enable) begin
      if (length_load) begin
        len_cnt <= length_in;
      end else if (take_tick && (len_cnt != 8'd0)) begin
        len_cnt <= len_cnt - 8'd1;
      end
    end
  end

  // A load in the same cycle suppresses the decrement, so it also suppresses the stop
  assign len_expire = take_tick & ~length_load & (len_cnt == 8'd1);
`else
  logic unused_length;
  assign unused_length = ^{length_load, length_in};
  assign len_expire    = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      position_out <= 5'd0;
      active       <= 1'b0;
      s0_valid     <= 1'b0;
      s0_pos       <= 5'd0;
      s1_valid     <= 1'b0;
      s1_nib       <= 4'd0;
      sample_out   <= 4'd0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (enable) begin
        if (take_trig) begin
          position_out <= 5'd0;
          active       <= 1'b1;
        end else if (take_tick) begin
          position_out <= position_out + 5'd1;
          if (len_expire) begin
            active <= 1'b0;
          end
        end
        s0_valid <= take_trig | take_tick;
        s0_pos   <= take_trig ? 5'd0 : position_out;
        s1_valid <= s0_valid;
        if (s0_valid) begin
          s1_nib <= rd_nib;
        end
        // The expiring tick's own sample still drains; sample_out clears once idle and stopped
        if (s1_valid) begin
          sample_out   <= atten;
          sample_valid <= 1'b1;
        end else if (!active) begin
          sample_out <= 4'd0;
        end
      end
    end
  end

endmodule
